// File: rtl/decoder_seq.sv
// decoder_seq: registered N-to-2**N one-hot decoder with two modes.
// DECODE latches a select through a valid/ready handshake.
// SCAN walks a single active line across all outputs, stepping once every
// SCAN_DIV enabled clock cycles, for row/digit strobing.
// Outputs are inverted when ACTIVE_LOW is nonzero.
module decoder_seq #(
    parameter int N          = 3,
    parameter int ACTIVE_LOW = 0,
    parameter int SCAN_DIV   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              sel_valid,
    input  logic [N-1:0]      sel,
    output logic              sel_ready,
    output logic [2**N-1:0]   y,
    output logic              y_valid,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int W     = 2**N;
    localparam int DIV_W = $clog2(SCAN_DIV) + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    // Output pattern when no line is selected, in the configured polarity.
    localparam logic [W-1:0]     Y_IDLE   = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [N-1:0]     IDX_LAST = {N{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     idx_q, idx_d;
    logic             y_valid_q, y_valid_d;
    logic [W-1:0]     y_q, y_d;
    logic             wrap_q, wrap_d;
    logic [DIV_W-1:0] div_q, div_d;

    // Builds the output pattern: one active line at i when valid, none otherwise.
    function automatic logic [W-1:0] drive_y(input logic valid, input logic [N-1:0] i);
        logic [W-1:0] oh;
        oh = '0;
        if (valid) begin
            oh[i] = 1'b1;
        end
        return (ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    // A select can only be taken in DECODE mode while enabled and out of reset.
    assign sel_ready = en & ~mode & ~rst;

    // Next-state logic: handshake capture in DECODE, divided stepping in SCAN,
    // everything held while en is low; wrap defaults low so it only ever pulses.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        y_valid_d = y_valid_q;
        div_d     = div_q;
        wrap_d    = 1'b0;

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (mode) begin
                        state_d   = ST_SCAN;
                        idx_d     = '0;
                        y_valid_d = 1'b1;
                        div_d     = '0;
                    end else if (sel_valid) begin
                        state_d   = ST_DECODE;
                        idx_d     = sel;
                        y_valid_d = 1'b1;
                        div_d     = '0;
                    end
                end
                ST_DECODE: begin
                    if (mode) begin
                        state_d = ST_SCAN;
                        div_d   = '0;
                    end else if (sel_valid) begin
                        idx_d     = sel;
                        y_valid_d = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        state_d = ST_DECODE;
                        div_d   = '0;
                    end else if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        idx_d  = idx_q + N'(1);
                        wrap_d = (idx_q == IDX_LAST);
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    idx_d     = '0;
                    y_valid_d = 1'b0;
                    div_d     = '0;
                end
            endcase
        end

        y_d = drive_y(y_valid_d, idx_d);
    end

    // State registers with synchronous reset that overrides en and mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            y_valid_q <= 1'b0;
            y_q       <= Y_IDLE;
            wrap_q    <= 1'b0;
            div_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            y_valid_q <= y_valid_d;
            y_q       <= y_d;
            wrap_q    <= wrap_d;
            div_q     <= div_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign idx     = idx_q;
    assign wrap    = wrap_q;

endmodule
